// File: rtl/video_verify_pkg.sv
// Shared types and constants for the HDMI receive-side verification path.
package video_verify_pkg;

  localparam int COORD_W = 12;
  localparam logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}};
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic {SYNC_WAIT, FRAME} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Counter increment that sticks at the all-ones value.
  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == COORD_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/crc16_ccitt_24.sv
// Combinational CRC-16-CCITT advance over one 24-bit pixel, MSB first,
// no reflection.
module crc16_ccitt_24
  import video_verify_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [23:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] acc;

  // Shift the 24 data bits through the LFSR, most significant bit first.
  always_comb begin
    acc = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (acc[15] ^ data[i]) begin
        acc = {acc[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        acc = {acc[14:0], 1'b0};
      end
    end
    crc_out = acc;
  end

endmodule

// File: rtl/video_frame_analyzer.sv
// Pixel-stream frame analyzer: measures active width/height, CRCs the
// active pixels and counts frames, publishing results on each vsync edge.
// Optional macro LINE_CHECK_EN adds a per-frame line-width consistency flag.
module video_frame_analyzer
  import video_verify_pkg::*;
#(
  parameter logic [11:0] H_ACTIVE = 12'd1920,
  parameter logic [11:0] V_ACTIVE = 12'd1080,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  output logic        frame_done,
  output logic [11:0] measured_h,
  output logic [11:0] measured_v,
  output logic [15:0] frame_crc,
  output logic        size_err,
  output logic        line_err,
  output logic [15:0] frame_count
);

  state_t       state;
  logic         de_r;
  logic         hsync_r;
  logic         vsync_r;
  pixel_t       pix_r;
  logic         de_d;
  logic         vsync_d;
  logic [11:0]  pix_cnt;
  logic [11:0]  line_cnt;
  logic [11:0]  first_w;
  logic [15:0]  crc;

  logic         vs_rise;
  logic         de_fall;
  logic [11:0]  line_cnt_end;
  logic [11:0]  first_w_end;
  logic [15:0]  crc_base;
  logic [15:0]  crc_next;
  logic         unused_hsync;

  assign unused_hsync = hsync_r;

  assign vs_rise = vsync_r & ~vsync_d;
  assign de_fall = de_d & ~de_r;

  // A line closing in the same cycle as the frame edge still belongs to the old frame.
  assign line_cnt_end = de_fall ? sat_inc(line_cnt) : line_cnt;
  assign first_w_end  = (de_fall && (line_cnt == '0)) ? pix_cnt : first_w;

  // At a frame edge the pixel in flight seeds the new frame from CRC_INIT.
  assign crc_base = vs_rise ? CRC_INIT : crc;

  crc16_ccitt_24 u_crc (
    .crc_in  (crc_base),
    .data    (pix_r),
    .crc_out (crc_next)
  );

`ifdef LINE_CHECK_EN
  logic width_flag;
  logic width_miss;

  assign width_miss = de_fall && (line_cnt != '0) && (pix_cnt != first_w);
`else
  assign line_err = 1'b0;
`endif

  // Input capture, edge history, frame state machine and result latching.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC_WAIT;
      de_r        <= 1'b0;
      hsync_r     <= 1'b0;
      vsync_r     <= 1'b0;
      pix_r       <= '0;
      de_d        <= 1'b0;
      vsync_d     <= 1'b0;
      pix_cnt     <= '0;
      line_cnt    <= '0;
      first_w     <= '0;
      crc         <= CRC_INIT;
      frame_done  <= 1'b0;
      measured_h  <= '0;
      measured_v  <= '0;
      frame_crc   <= '0;
      size_err    <= 1'b0;
      frame_count <= '0;
`ifdef LINE_CHECK_EN
      width_flag  <= 1'b0;
      line_err    <= 1'b0;
`endif
    end else begin
      de_r       <= de;
      hsync_r    <= hsync;
      vsync_r    <= vsync;
      pix_r      <= '{r: red, g: green, b: blue};
      de_d       <= de_r;
      vsync_d    <= vsync_r;
      frame_done <= 1'b0;

      case (state)
        SYNC_WAIT: begin
          if (vs_rise) begin
            state    <= FRAME;
            line_cnt <= '0;
            first_w  <= '0;
            pix_cnt  <= de_r ? 12'd1 : 12'd0;
            crc      <= de_r ? crc_next : CRC_INIT;
`ifdef LINE_CHECK_EN
            width_flag <= 1'b0;
`endif
          end
        end

        FRAME: begin
          if (vs_rise) begin
            measured_h  <= first_w_end;
            measured_v  <= line_cnt_end;
            frame_crc   <= crc;
            size_err    <= (first_w_end != H_ACTIVE) || (line_cnt_end != V_ACTIVE);
            frame_count <= frame_count + 16'd1;
            frame_done  <= 1'b1;
            line_cnt    <= '0;
            first_w     <= '0;
            pix_cnt     <= de_r ? 12'd1 : 12'd0;
            crc         <= de_r ? crc_next : CRC_INIT;
`ifdef LINE_CHECK_EN
            line_err   <= width_flag | width_miss;
            width_flag <= 1'b0;
`endif
          end else begin
            if (de_r) begin
              pix_cnt <= sat_inc(pix_cnt);
              crc     <= crc_next;
            end
            if (de_fall) begin
              line_cnt <= line_cnt_end;
              first_w  <= first_w_end;
              pix_cnt  <= '0;
`ifdef LINE_CHECK_EN
              if (width_miss) begin
                width_flag <= 1'b1;
              end
`endif
            end
          end
        end

        default: state <= SYNC_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_video_frame_analyzer.sv
// Self-checking bench for video_frame_analyzer with a tiny 8x4 raster.
module tb_video_frame_analyzer;

  localparam logic [11:0] H = 12'd8;
  localparam logic [11:0] V = 12'd4;
`ifdef LINE_CHECK_EN
  localparam logic LC = 1'b1;
`else
  localparam logic LC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        de, hsync, vsync;
  logic [7:0]  red, green, blue;
  logic        frame_done;
  logic [11:0] measured_h, measured_v;
  logic [15:0] frame_crc;
  logic        size_err, line_err;
  logic [15:0] frame_count;

  video_frame_analyzer #(.H_ACTIVE(H), .V_ACTIVE(V), .CRC_INIT(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .de(de), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .frame_done(frame_done),
    .measured_h(measured_h), .measured_v(measured_v), .frame_crc(frame_crc),
    .size_err(size_err), .line_err(line_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              nlines;
    logic [5:0][3:0] widths;
    int              mode;
    bit              coinc;
    logic [11:0]     exp_h;
    logic [11:0]     exp_v;
    logic            exp_size;
    logic            exp_line;
    logic [15:0]     exp_count;
  } frame_vec_t;

  frame_vec_t  frames [10];
  int          tests = 0;
  int          fails = 0;
  int          mode;
  int          pix_idx;
  logic [15:0] model_crc;
  logic [15:0] exp_crc;
  int          done_at;
  int          done_pulses;
  logic [11:0] cap_h, cap_v;
  logic [15:0] cap_crc, cap_count;
  logic        cap_size, cap_line;
  logic [15:0] crc_inc, crc_swap;

  // Reference CRC-16-CCITT, one 24-bit word, MSB first.
  function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [23:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [23:0] pixelFor(input int m, input int n);
    int k;
    k = n;
    if (m == 2 && n == 0) k = 1;
    if (m == 2 && n == 1) k = 0;
    if (m == 0) return 24'h0;
    return {k[7:0], k[7:0], k[7:0]};
  endfunction

  function automatic frame_vec_t mkFrame(input int n, input int w, input int m, input bit c,
                                         input logic [11:0] h, input logic [11:0] v,
                                         input logic s, input logic l, input logic [15:0] cnt);
    frame_vec_t f;
    f.nlines = n;
    for (int i = 0; i < 6; i++) f.widths[i] = w[3:0];
    f.mode = m; f.coinc = c; f.exp_h = h; f.exp_v = v;
    f.exp_size = s; f.exp_line = l; f.exp_count = cnt;
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sendPixel();
    logic [23:0] p;
    p = pixelFor(mode, pix_idx);
    de = 1'b1;
    {red, green, blue} = p;
    model_crc = crcStep(model_crc, p);
    pix_idx++;
    @(negedge clk);
  endtask

  task automatic sendGap();
    de = 1'b0;
    {red, green, blue} = 24'h0;
    hsync = 1'b1;
    @(negedge clk);
    hsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Raise vsync (optionally dropping de in the same cycle) and watch for frame_done.
  task automatic pulseVsync(input bit drop_de);
    exp_crc = model_crc;
    vsync = 1'b1;
    if (drop_de) begin
      de = 1'b0;
      {red, green, blue} = 24'h0;
    end
    done_at = -1;
    done_pulses = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (frame_done) begin
        done_pulses++;
        if (done_at < 0) begin
          done_at = k;
          cap_h = measured_h; cap_v = measured_v; cap_crc = frame_crc;
          cap_size = size_err; cap_line = line_err; cap_count = frame_count;
        end
      end
      if (k == 3) vsync = 1'b0;
    end
    model_crc = 16'hFFFF;
    pix_idx = 0;
  endtask

  task automatic applyStimulus(input frame_vec_t f);
    mode = f.mode;
    for (int l = 0; l < f.nlines; l++) begin
      repeat (int'(f.widths[l])) sendPixel();
      if (!(f.coinc && l == f.nlines - 1)) sendGap();
    end
    pulseVsync(f.coinc);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, " frame_done"}, frame_done, 0);
    checkOutput({tag, " measured_h"}, measured_h, 0);
    checkOutput({tag, " measured_v"}, measured_v, 0);
    checkOutput({tag, " frame_crc"}, frame_crc, 0);
    checkOutput({tag, " size_err"}, size_err, 0);
    checkOutput({tag, " line_err"}, line_err, 0);
    checkOutput({tag, " frame_count"}, frame_count, 0);
  endtask

  initial begin
    frames[0] = mkFrame(4, 8, 0, 0, 8, 4, 0, 0, 1);
    frames[1] = mkFrame(4, 8, 0, 0, 8, 4, 0, 0, 2);
    frames[2] = mkFrame(4, 8, 0, 0, 8, 4, 0, 0, 3);
    frames[3] = mkFrame(5, 8, 0, 0, 8, 5, 1, 0, 4);
    frames[4] = mkFrame(4, 8, 0, 0, 8, 4, 0, 0, 5);
    frames[5] = mkFrame(4, 8, 0, 0, 8, 4, 0, LC, 6);
    frames[5].widths[2] = 4'd7;
    frames[6] = mkFrame(4, 8, 0, 1, 8, 4, 0, 0, 7);
    frames[7] = mkFrame(4, 8, 1, 0, 8, 4, 0, 0, 8);
    frames[8] = mkFrame(4, 8, 2, 0, 8, 4, 0, 0, 9);
    frames[9] = mkFrame(0, 8, 0, 0, 0, 0, 1, 0, 10);

    rst_n = 1'b0; de = 0; hsync = 0; vsync = 0; {red, green, blue} = 24'h0;
    model_crc = 16'hFFFF; pix_idx = 0; mode = 0;
    repeat (3) @(negedge clk);
    checkZero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Partial frame before the first edge must be discarded silently.
    mode = 1;
    repeat (5) sendPixel();
    sendGap();
    pulseVsync(1'b0);
    checkOutput("first edge no done", done_pulses, 0);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(frames[i]);
      checkOutput($sformatf("f%0d done latency", i), done_at, 2);
      checkOutput($sformatf("f%0d done pulses", i), done_pulses, 1);
      checkOutput($sformatf("f%0d measured_h", i), cap_h, frames[i].exp_h);
      checkOutput($sformatf("f%0d measured_v", i), cap_v, frames[i].exp_v);
      checkOutput($sformatf("f%0d frame_crc", i), cap_crc, exp_crc);
      checkOutput($sformatf("f%0d size_err", i), cap_size, frames[i].exp_size);
      checkOutput($sformatf("f%0d line_err", i), cap_line, frames[i].exp_line);
      checkOutput($sformatf("f%0d frame_count", i), cap_count, frames[i].exp_count);
      if (i == 7) crc_inc = cap_crc;
      if (i == 8) crc_swap = cap_crc;
    end
    checkOutput("zero-line crc", cap_crc, 16'hFFFF);
    checkOutput("swap changes crc", crc_inc != crc_swap, 1);

    // Reset mid-frame after 10 pixels clears everything immediately.
    mode = 0;
    repeat (8) sendPixel();
    sendGap();
    repeat (2) sendPixel();
    rst_n = 1'b0;
    #1;
    checkZero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) sendPixel();
    sendGap();
    for (int l = 0; l < 2; l++) begin
      repeat (8) sendPixel();
      sendGap();
    end
    pulseVsync(1'b0);
    checkOutput("post-reset first edge no done", done_pulses, 0);
    applyStimulus(mkFrame(4, 8, 0, 0, 8, 4, 0, 0, 1));
    checkOutput("post-reset done latency", done_at, 2);
    checkOutput("post-reset frame_count", cap_count, 16'd1);
    checkOutput("post-reset measured_h", cap_h, 12'd8);
    checkOutput("post-reset measured_v", cap_v, 12'd4);
    checkOutput("post-reset frame_crc", cap_crc, exp_crc);
    checkOutput("post-reset size_err", cap_size, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
